tile_frame_renderer: RTL

- Reader end of the level→display interface. A level block writes the tile map `background[11:0][16:0]` and the character positions; this block reads them and converts each VGA pixel coordinate into a 12-bit RGB value.
- Sits between the VGA timing generator and the DAC pins. Pipelined, fixed latency; sync signals are delayed to stay aligned with the colour output.
- Also owns the token blink animation, driven by a frame counter.

---
 rtl/tile_pkg.sv | 47 ++++
 rtl/tile_palette.sv | 40 ++++
 rtl/tile_frame_renderer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_pkg: tile codes, palette, geometry and tile-map type shared by   |
// | the tile frame renderer.                          Revision: 1.0       |
// +----------------------------------------------------------------------+
package tile_pkg;

    typedef logic [7:0] tile_code_t;
    typedef tile_code_t [11:0][16:0] tile_map_t;

    localparam tile_code_t BDR = 8'd0;
    localparam tile_code_t SKY = 8'd1;
    localparam tile_code_t BLK = 8'd2;
    localparam tile_code_t GND = 8'd3;
    localparam tile_code_t TKN = 8'd4;
    localparam tile_code_t CK1 = 8'd5;
    localparam tile_code_t CK2 = 8'd6;

    localparam logic [11:0] COL_BLACK    = 12'h000;
    localparam logic [11:0] COL_WHITE    = 12'hFFF;
    localparam logic [11:0] COL_SKY      = 12'h6AF;
    localparam logic [11:0] COL_BLK      = 12'hA52;
    localparam logic [11:0] COL_BLK_EDGE = 12'h310;
    localparam logic [11:0] COL_GND      = 12'h740;
    localparam logic [11:0] COL_TKN      = 12'hFD0;
    localparam logic [11:0] COL_MARIO    = 12'hF00;
    localparam logic [11:0] COL_GOOMBA   = 12'h840;
    localparam logic [11:0] COL_DEBUG    = 12'hF0F;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BLOCK_WIDTH   = 40;
    localparam int SCREEN_COLS   = 16;
    localparam int SCREEN_ROWS   = 12;
    localparam int MAP_COLS      = 17;

    localparam logic [5:0] OFS_LAST = 6'd39;
    localparam logic [5:0] TKN_LO   = 6'd10;
    localparam logic [5:0] TKN_HI   = 6'd29;

    function automatic logic in_window(input logic [5:0] v, input logic [5:0] lo,
                                       input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_palette.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_palette: maps tile code, intra-tile offset and blink phase to a  |
// | 12-bit RGB colour (combinational).                Revision: 1.0       |
// +----------------------------------------------------------------------+
module tile_palette
    import tile_pkg::*;
(
    input  logic [7:0]  tile_code,
    input  logic [5:0]  ox,
    input  logic [5:0]  oy,
    input  logic        blink_phase,
    output logic [11:0] colour
);

    logic w_outline;
    logic w_coin_area;
    logic w_checker;

    assign w_outline   = (ox == 6'd0) || (ox == OFS_LAST) || (oy == 6'd0) || (oy == OFS_LAST);
    assign w_coin_area = in_window(ox, TKN_LO, TKN_HI) && in_window(oy, TKN_LO, TKN_HI);
    assign w_checker   = ox[3] ^ oy[3];

    always_comb begin
        colour = COL_DEBUG;
        case (tile_code)
            BDR:     colour = COL_BLACK;
            SKY:     colour = COL_SKY;
            BLK:     colour = w_outline ? COL_BLK_EDGE : COL_BLK;
            GND:     colour = COL_GND;
            // Coin is drawn only in the visible blink phase; otherwise it shows sky.
            TKN:     colour = (!blink_phase && w_coin_area) ? COL_TKN : COL_SKY;
            CK1:     colour = w_checker ? COL_WHITE : COL_BLACK;
            CK2:     colour = w_checker ? COL_BLACK : COL_WHITE;
            default: colour = COL_DEBUG;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tile_frame_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_frame_renderer: two-stage pixel pipeline turning VGA coordinates |
// | into tile/sprite colour, with token blink animation. Revision: 1.0    |
// +----------------------------------------------------------------------+
module tile_frame_renderer
    import tile_pkg::*;
#(
    parameter int CHARACTER_WIDTH = 42,
    parameter int BLINK_FRAMES    = 15
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  tile_map_t   background,
    input  int          mario_x,
    input  int          mario_y,
    input  int          goomba_x,
    input  int          goomba_y,
    input  int          goomba_2x,
    input  int          goomba_2y,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [7:0] c_last_frame = 8'(BLINK_FRAMES - 1);

    logic [3:0] w_col;
    logic [3:0] w_row;
    logic [9:0] w_col_base;
    logic [9:0] w_row_base;
    logic [5:0] w_ox;
    logic [5:0] w_oy;

    logic [3:0] r_s1_col;
    logic [3:0] r_s1_row;
    logic [5:0] r_s1_ox;
    logic [5:0] r_s1_oy;
    logic [9:0] r_s1_px;
    logic [9:0] r_s1_py;
    logic       r_s1_video;
    logic       r_s1_hsync;
    logic       r_s1_vsync;

    logic       r_vsync_prev;
    logic [7:0] r_frame_count;
    logic       r_blink_phase;
    logic       w_vsync_fall;

    logic [4:0]  w_tx;
    logic [3:0]  w_ty;
    tile_code_t  w_code;
    logic [11:0] w_tile_rgb;
    logic [11:0] w_rgb;
    int          w_px;
    int          w_py;
    logic        w_off_screen;

    // Tile column/row by threshold comparison; the base is the tile's left/top pixel.
    always_comb begin
        w_col      = '0;
        w_col_base = '0;
        for (int k = 1; k < SCREEN_COLS; k++) begin
            if (pixel_x >= 10'(k * BLOCK_WIDTH)) begin
                w_col      = 4'(k);
                w_col_base = 10'(k * BLOCK_WIDTH);
            end
        end
        w_row      = '0;
        w_row_base = '0;
        for (int k = 1; k < SCREEN_ROWS; k++) begin
            if (pixel_y >= 10'(k * BLOCK_WIDTH)) begin
                w_row      = 4'(k);
                w_row_base = 10'(k * BLOCK_WIDTH);
            end
        end
    end

    assign w_ox = 6'(pixel_x - w_col_base);
    assign w_oy = 6'(pixel_y - w_row_base);

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_ox    <= '0;
            r_s1_oy    <= '0;
            r_s1_px    <= '0;
            r_s1_py    <= '0;
            r_s1_video <= 1'b0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
        end else begin
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            r_s1_ox    <= w_ox;
            r_s1_oy    <= w_oy;
            r_s1_px    <= pixel_x;
            r_s1_py    <= pixel_y;
            r_s1_video <= video_on;
            r_s1_hsync <= hsync_in;
            r_s1_vsync <= vsync_in;
        end
    end

    assign w_vsync_fall = r_vsync_prev & ~vsync_in;

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_vsync_prev  <= 1'b0;
            r_frame_count <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_vsync_fall) begin
                if (r_frame_count == c_last_frame) begin
                    r_frame_count <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_count <= r_frame_count + 8'd1;
                end
            end
        end
    end

    // Map is stored mirrored: screen top-left is map entry [11][16].
    assign w_tx   = 5'(MAP_COLS - 1) - {1'b0, r_s1_col};
    assign w_ty   = 4'(SCREEN_ROWS - 1) - r_s1_row;
    assign w_code = background[w_ty][w_tx];

    tile_palette u_palette (
        .tile_code   (w_code),
        .ox          (r_s1_ox),
        .oy          (r_s1_oy),
        .blink_phase (r_blink_phase),
        .colour      (w_tile_rgb)
    );

    assign w_px = int'({22'd0, r_s1_px});
    assign w_py = int'({22'd0, r_s1_py});

    function automatic logic box_hit(input int px, input int py, input int bx, input int by);
        return (px >= bx) && (px < bx + CHARACTER_WIDTH) &&
               (py >= by) && (py < by + CHARACTER_WIDTH);
    endfunction

    assign w_off_screen = (r_s1_px >= 10'(SCREEN_WIDTH)) || (r_s1_py >= 10'(SCREEN_HEIGHT));

    always_comb begin
        w_rgb = w_tile_rgb;
        if (!r_s1_video || w_off_screen) begin
            w_rgb = COL_BLACK;
        end else if (box_hit(w_px, w_py, mario_x, mario_y)) begin
            w_rgb = COL_MARIO;
        end else if (box_hit(w_px, w_py, goomba_x, goomba_y)) begin
            w_rgb = COL_GOOMBA;
        end else if (box_hit(w_px, w_py, goomba_2x, goomba_2y)) begin
            w_rgb = COL_GOOMBA;
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            red       <= w_rgb[11:8];
            green     <= w_rgb[7:4];
            blue      <= w_rgb[3:0];
            hsync_out <= r_s1_hsync;
            vsync_out <= r_s1_vsync;
        end
    end

endmodule
`default_nettype wire
